// File: rtl/alu_result_fifo.sv
// Registered FIFO for ALU results {sel, c, y} with a saturating carry-out counter.
// Optional per-entry even parity is enabled by defining ALU_RESULT_FIFO_PARITY_EN.
module alu_result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_sel,
   input  logic [WIDTH-1:0]           in_y,
   input  logic                       in_c,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2:0]                 out_sel,
   output logic [WIDTH-1:0]           out_y,
   output logic                       out_c,
   output logic                       out_par,
   output logic [$clog2(DEPTH):0]     level,
   output logic [7:0]                 carry_cnt,
   input  logic                       cnt_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             wr;
   logic             rd;

   logic [2:0]       mem_sel [DEPTH];
   logic             mem_c   [DEPTH];
   logic [WIDTH-1:0] mem_y   [DEPTH];

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1. in_ready and out_valid come only from the registered occupancy,
   // so neither depends on in_valid or out_ready in the same cycle.
   assign in_ready  = (count != LW'(DEPTH));
   assign out_valid = (count != '0);
   assign wr        = in_valid & in_ready;
   assign rd        = out_valid & out_ready;
   assign level     = count;

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_sel[wr_ptr] <= in_sel;
         mem_c[wr_ptr]   <= in_c;
         mem_y[wr_ptr]   <= in_y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         carry_cnt <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + PW'(1);
         if (rd) rd_ptr <= rd_ptr + PW'(1);
         case ({wr, rd})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
         // Clear beats a simultaneous carry write; the count sticks at 255.
         if (cnt_clr)
            carry_cnt <= '0;
         else if (wr && in_c && (carry_cnt != 8'hFF))
            carry_cnt <= carry_cnt + 8'd1;
      end
   end

   assign out_sel = out_valid ? mem_sel[rd_ptr] : '0;
   assign out_c   = out_valid ? mem_c[rd_ptr]   : 1'b0;
   assign out_y   = out_valid ? mem_y[rd_ptr]   : '0;

`ifdef ALU_RESULT_FIFO_PARITY_EN
   logic mem_par [DEPTH];

   always_ff @(posedge clk) begin
      if (wr) mem_par[wr_ptr] <= ^{in_sel, in_c, in_y};
   end

   assign out_par = out_valid ? mem_par[rd_ptr] : 1'b0;
`else
   assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed vector table, hand-written corner sequences
// and random traffic checked against a queue-based reference model.
module tb_alu_result_fifo;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int EW    = 3 + 1 + WIDTH;
`ifdef ALU_RESULT_FIFO_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_sel;
   logic [WIDTH-1:0] in_y;
   logic             in_c;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_sel;
   logic [WIDTH-1:0] out_y;
   logic             out_c;
   logic             out_par;
   logic [LW-1:0]    level;
   logic [7:0]       carry_cnt;
   logic             cnt_clr;

   always #5 clk = ~clk;

   alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_y      (in_y),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel),
      .out_y     (out_y),
      .out_c     (out_c),
      .out_par   (out_par),
      .level     (level),
      .carry_cnt (carry_cnt),
      .cnt_clr   (cnt_clr)
   );

   // ---------------- scoreboard / reference model ----------------
   logic [EW-1:0] exp_q[$];   // entries as {sel, c, y}, head at index 0
   int            exp_cnt;
   int            checks;
   int            errors;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_model();
      int            n;
      logic [EW-1:0] h;
      n = exp_q.size();
      h = '0;
      if (n > 0) h = exp_q[0];
      check("level",     int'(level),     n);
      check("out_valid", int'(out_valid), (n > 0) ? 1 : 0);
      check("in_ready",  int'(in_ready),  (n < DEPTH) ? 1 : 0);
      check("out_sel",   int'(out_sel),   int'(h[EW-1 -: 3]));
      check("out_c",     int'(out_c),     int'(h[WIDTH]));
      check("out_y",     int'(out_y),     int'(h[WIDTH-1:0]));
      check("out_par",   int'(out_par),   (PAR_EN && n > 0) ? int'(^h) : 0);
      check("carry_cnt", int'(carry_cnt), exp_cnt);
   endtask

   // ---------------- driver ----------------
   // One clock cycle: drive inputs, predict, clock, update model, compare.
   task automatic step(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] y,
                       input logic c, input logic ordy, input logic clr, input logic r);
      bit do_wr;
      bit do_rd;
      in_valid  = v;
      in_sel    = s;
      in_y      = y;
      in_c      = c;
      out_ready = ordy;
      cnt_clr   = clr;
      rst       = r;
      do_wr = v && (exp_q.size() < DEPTH);
      do_rd = ordy && (exp_q.size() > 0);
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         exp_cnt = 0;
      end else begin
         if (do_rd) void'(exp_q.pop_front());
         if (do_wr) exp_q.push_back({s, c, y});
         if (clr) exp_cnt = 0;
         else if (do_wr && c && exp_cnt < 255) exp_cnt++;
      end
      check_model();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic             v;
      logic [2:0]       s;
      logic [WIDTH-1:0] y;
      logic             c;
      logic             ordy;
      logic             clr;
      int               e_level;
      logic [WIDTH-1:0] e_y;
      logic [2:0]       e_sel;
      logic             e_c;
      int               e_cnt;
   } vec_t;

   vec_t tbl[16];

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = 0;

      //            v  sel   y     c  ordy clr  lvl  e_y   e_sel e_c cnt
      tbl[0]  = '{1, 3'd0, 4'hA, 1, 0, 0,   1, 4'hA, 3'd0, 1, 1};
      tbl[1]  = '{1, 3'd1, 4'h3, 0, 0, 0,   2, 4'hA, 3'd0, 1, 1};
      tbl[2]  = '{0, 3'd0, 4'h0, 0, 1, 0,   1, 4'h3, 3'd1, 0, 1};
      tbl[3]  = '{0, 3'd0, 4'h0, 0, 1, 0,   0, 4'h0, 3'd0, 0, 1};
      tbl[4]  = '{1, 3'd2, 4'h5, 1, 0, 0,   1, 4'h5, 3'd2, 1, 2};
      tbl[5]  = '{1, 3'd3, 4'h6, 0, 0, 0,   2, 4'h5, 3'd2, 1, 2};
      tbl[6]  = '{1, 3'd4, 4'h7, 1, 0, 0,   3, 4'h5, 3'd2, 1, 3};
      tbl[7]  = '{1, 3'd5, 4'h8, 0, 0, 0,   4, 4'h5, 3'd2, 1, 3};
      tbl[8]  = '{1, 3'd6, 4'h9, 1, 0, 0,   4, 4'h5, 3'd2, 1, 3};
      tbl[9]  = '{1, 3'd6, 4'h9, 1, 1, 0,   3, 4'h6, 3'd3, 0, 3};
      tbl[10] = '{0, 3'd0, 4'h0, 0, 1, 0,   2, 4'h7, 3'd4, 1, 3};
      tbl[11] = '{0, 3'd0, 4'h0, 0, 1, 0,   1, 4'h8, 3'd5, 0, 3};
      tbl[12] = '{0, 3'd0, 4'h0, 0, 1, 0,   0, 4'h0, 3'd0, 0, 3};
      tbl[13] = '{0, 3'd0, 4'h0, 0, 1, 0,   0, 4'h0, 3'd0, 0, 3};
      tbl[14] = '{1, 3'd7, 4'h1, 1, 0, 1,   1, 4'h1, 3'd7, 1, 0};
      tbl[15] = '{0, 3'd0, 4'h0, 0, 1, 0,   0, 4'h0, 3'd0, 0, 0};

      // reset, then idle
      step(0, 3'd0, '0, 0, 0, 0, 1);
      step(0, 3'd0, '0, 0, 0, 0, 1);
      step(0, 3'd0, '0, 0, 0, 0, 0);
      check("rst_level",    int'(level),     0);
      check("rst_in_ready", int'(in_ready),  1);
      check("rst_out_y",    int'(out_y),     0);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].y, tbl[i].c, tbl[i].ordy, tbl[i].clr, 0);
         check($sformatf("vec%0d_level", i),     int'(level),     tbl[i].e_level);
         check($sformatf("vec%0d_out_valid", i), int'(out_valid), (tbl[i].e_level != 0) ? 1 : 0);
         check($sformatf("vec%0d_in_ready", i),  int'(in_ready),  (tbl[i].e_level != DEPTH) ? 1 : 0);
         check($sformatf("vec%0d_out_y", i),     int'(out_y),     int'(tbl[i].e_y));
         check($sformatf("vec%0d_out_sel", i),   int'(out_sel),   int'(tbl[i].e_sel));
         check($sformatf("vec%0d_out_c", i),     int'(out_c),     int'(tbl[i].e_c));
         check($sformatf("vec%0d_carry_cnt", i), int'(carry_cnt), tbl[i].e_cnt);
      end

      // streaming at level 2 with pointer wrap
      step(1, 3'd2, 4'h0, 0, 0, 0, 0);
      step(1, 3'd2, 4'h1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(1, 3'(i % 8), WIDTH'(i + 2), 0, 1, 0, 0);
         check("stream_level", int'(level), 2);
         check("stream_out_y", int'(out_y), (i + 1) % 16);
      end
      step(0, 3'd0, '0, 0, 1, 0, 0);
      step(0, 3'd0, '0, 0, 1, 0, 0);

      // carry counter saturation, then clear beating a carry write
      for (int i = 0; i < 300; i++)
         step(1, 3'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 15)), 1, 1, 0, 0);
      check("sat_carry_cnt", int'(carry_cnt), 255);
      step(1, 3'd0, 4'h0, 1, 1, 1, 0);
      check("clr_carry_cnt", int'(carry_cnt), 0);

      // reset mid-stream drops entries and same-cycle traffic
      step(1, 3'd3, 4'hC, 1, 0, 0, 0);
      step(1, 3'd3, 4'hD, 1, 0, 0, 0);
      step(1, 3'd3, 4'hE, 1, 1, 0, 1);
      check("midrst_level", int'(level), 0);
      check("midrst_carry", int'(carry_cnt), 0);
      check("midrst_valid", int'(out_valid), 0);

      // parity of head entry
      step(1, 3'd4, 4'h7, 0, 0, 0, 0);
      check("par_a", int'(out_par), 0);
      step(1, 3'd1, 4'h1, 1, 1, 0, 0);
      check("par_b", int'(out_par), PAR_EN ? 1 : 0);
      step(0, 3'd0, '0, 0, 1, 0, 0);
      check("par_empty", int'(out_par), 0);

      // random traffic against the model
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
              $urandom_range(0, 120) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
